// File: rtl/vec_cache_sram_pair_rd_sched.sv
// Two-port read-request scheduler in front of the paired SRAM group.
// Each port has a small FIFO. The two FIFO heads are issued to SRAM slots a and b
// in the same cycle unless they target the same channel_id. In that case a
// round-robin pointer picks one head, and the other head waits in its FIFO.
// Tags travel through an RD_LAT-deep pipeline so that each tag lines up with its
// read data.
// The command is a flat CMD_W-bit image of sram_inst_cmd_t. Its MSB is
// dest_ram_id.channel_id.
module vec_cache_sram_pair_rd_sched #(
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned CMD_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld_a,
  output logic             req_rdy_a,
  input  logic [CMD_W-1:0] req_cmd_a,
  input  logic [TAG_W-1:0] req_tag_a,
  input  logic             req_vld_b,
  output logic             req_rdy_b,
  input  logic [CMD_W-1:0] req_cmd_b,
  input  logic [TAG_W-1:0] req_tag_b,
  output logic             sram_read_vld_a,
  output logic [CMD_W-1:0] sram_read_cmd_a,
  output logic             sram_read_vld_b,
  output logic [CMD_W-1:0] sram_read_cmd_b,
  input  logic [31:0]      sram_rd_data_a,
  input  logic [31:0]      sram_rd_data_b,
  output logic             rsp_vld_a,
  output logic [TAG_W-1:0] rsp_tag_a,
  output logic [31:0]      rsp_data_a,
  output logic             rsp_vld_b,
  output logic [TAG_W-1:0] rsp_tag_b,
  output logic [31:0]      rsp_data_b
);

  localparam int unsigned CH_BIT = CMD_W - 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  // Port FIFO storage and pointers
  logic [CMD_W-1:0] cmd_mem_a_q [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem_a_q [FIFO_DEPTH];
  logic [CMD_W-1:0] cmd_mem_b_q [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem_b_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_a_q, rptr_a_q, wptr_b_q, rptr_b_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic             push_a, push_b, pop_a, pop_b;
  logic             hv_a, hv_b, conflict;
  logic [CMD_W-1:0] hcmd_a, hcmd_b;
  logic [TAG_W-1:0] htag_a, htag_b;
  logic             rr_q, rr_d;

  // Response pipelines of {vld, tag} for each slot
  logic [RD_LAT-1:0] pv_a_q, pv_b_q;
  logic [TAG_W-1:0]  pt_a_q [RD_LAT];
  logic [TAG_W-1:0]  pt_b_q [RD_LAT];

  // Ready depends only on registered occupancy
  assign req_rdy_a = (cnt_a_q != CNT_W'(FIFO_DEPTH));
  assign req_rdy_b = (cnt_b_q != CNT_W'(FIFO_DEPTH));
  assign push_a    = req_vld_a & req_rdy_a;
  assign push_b    = req_vld_b & req_rdy_b;

  assign hv_a   = (cnt_a_q != '0);
  assign hv_b   = (cnt_b_q != '0);
  assign hcmd_a = cmd_mem_a_q[rptr_a_q];
  assign hcmd_b = cmd_mem_b_q[rptr_b_q];
  assign htag_a = tag_mem_a_q[rptr_a_q];
  assign htag_b = tag_mem_b_q[rptr_b_q];

  // Arbitration between the heads. rr_q = 0 prefers port A on a same-channel conflict.
  always_comb begin
    conflict = hv_a & hv_b & (hcmd_a[CH_BIT] == hcmd_b[CH_BIT]);
    pop_a    = hv_a & (~conflict | ~rr_q);
    pop_b    = hv_b & (~conflict | rr_q);
    // On a conflict the pointer moves to the port that lost
    rr_d     = conflict ? ~rr_q : rr_q;
  end

  // Slot command drive. An idle slot a carries the inverse channel of slot b,
  // because the SRAM group routes on slot a's channel_id.
  always_comb begin
    sram_read_vld_a = pop_a;
    sram_read_vld_b = pop_b;
    sram_read_cmd_b = pop_b ? hcmd_b : '0;
    sram_read_cmd_a = '0;
    if (pop_a) begin
      sram_read_cmd_a = hcmd_a;
    end else begin
      sram_read_cmd_a[CH_BIT] = ~(pop_b & hcmd_b[CH_BIT]);
    end
  end

  // FIFO occupancy next-state
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    case ({push_a, pop_a})
      2'b10:   cnt_a_d = cnt_a_q + CNT_W'(1);
      2'b01:   cnt_a_d = cnt_a_q - CNT_W'(1);
      default: cnt_a_d = cnt_a_q;
    endcase
    case ({push_b, pop_b})
      2'b10:   cnt_b_d = cnt_b_q + CNT_W'(1);
      2'b01:   cnt_b_d = cnt_b_q - CNT_W'(1);
      default: cnt_b_d = cnt_b_q;
    endcase
  end

  // FIFO A state and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_a_q <= '0;
      rptr_a_q <= '0;
      cnt_a_q  <= '0;
    end else begin
      if (push_a) begin
        cmd_mem_a_q[wptr_a_q] <= req_cmd_a;
        tag_mem_a_q[wptr_a_q] <= req_tag_a;
        wptr_a_q              <= wptr_a_q + PTR_W'(1);
      end
      if (pop_a) rptr_a_q <= rptr_a_q + PTR_W'(1);
      cnt_a_q <= cnt_a_d;
    end
  end

  // FIFO B state and storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_b_q <= '0;
      rptr_b_q <= '0;
      cnt_b_q  <= '0;
    end else begin
      if (push_b) begin
        cmd_mem_b_q[wptr_b_q] <= req_cmd_b;
        tag_mem_b_q[wptr_b_q] <= req_tag_b;
        wptr_b_q              <= wptr_b_q + PTR_W'(1);
      end
      if (pop_b) rptr_b_q <= rptr_b_q + PTR_W'(1);
      cnt_b_q <= cnt_b_d;
    end
  end

  // Round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  // Response pipelines. Tags are zeroed when the slot is idle, so an idle slot presents tag 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_a_q <= '0;
      pv_b_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pt_a_q[i] <= '0;
        pt_b_q[i] <= '0;
      end
    end else begin
      pv_a_q[0] <= pop_a;
      pv_b_q[0] <= pop_b;
      pt_a_q[0] <= pop_a ? htag_a : '0;
      pt_b_q[0] <= pop_b ? htag_b : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_a_q[i] <= pv_a_q[i-1];
        pv_b_q[i] <= pv_b_q[i-1];
        pt_a_q[i] <= pt_a_q[i-1];
        pt_b_q[i] <= pt_b_q[i-1];
      end
    end
  end

  // Response outputs. Data is gated so that idle slots present zero.
  always_comb begin
    rsp_vld_a  = pv_a_q[RD_LAT-1];
    rsp_vld_b  = pv_b_q[RD_LAT-1];
    rsp_tag_a  = pt_a_q[RD_LAT-1];
    rsp_tag_b  = pt_b_q[RD_LAT-1];
    rsp_data_a = rsp_vld_a ? sram_rd_data_a : '0;
    rsp_data_b = rsp_vld_b ? sram_rd_data_b : '0;
  end

endmodule

// File: tb/tb_vec_cache_sram_pair_rd_sched.sv
// Directed bench for vec_cache_sram_pair_rd_sched. A behavioural one-cycle SRAM
// returns {16'hD0A0 or 16'hD0B0, cmd} for each slot read.
module tb_vec_cache_sram_pair_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld_a, req_rdy_a, req_vld_b, req_rdy_b;
  logic [15:0] req_cmd_a, req_cmd_b;
  logic [7:0]  req_tag_a, req_tag_b;
  logic        sram_read_vld_a, sram_read_vld_b;
  logic [15:0] sram_read_cmd_a, sram_read_cmd_b;
  logic [31:0] sram_rd_data_a, sram_rd_data_b;
  logic        rsp_vld_a, rsp_vld_b;
  logic [7:0]  rsp_tag_a, rsp_tag_b;
  logic [31:0] rsp_data_a, rsp_data_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         gseq[$];
  logic       rdyseq[$];

  vec_cache_sram_pair_rd_sched #(
    .TAG_W(8), .FIFO_DEPTH(2), .RD_LAT(1), .CMD_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld_a(req_vld_a), .req_rdy_a(req_rdy_a), .req_cmd_a(req_cmd_a), .req_tag_a(req_tag_a),
    .req_vld_b(req_vld_b), .req_rdy_b(req_rdy_b), .req_cmd_b(req_cmd_b), .req_tag_b(req_tag_b),
    .sram_read_vld_a(sram_read_vld_a), .sram_read_cmd_a(sram_read_cmd_a),
    .sram_read_vld_b(sram_read_vld_b), .sram_read_cmd_b(sram_read_cmd_b),
    .sram_rd_data_a(sram_rd_data_a), .sram_rd_data_b(sram_rd_data_b),
    .rsp_vld_a(rsp_vld_a), .rsp_tag_a(rsp_tag_a), .rsp_data_a(rsp_data_a),
    .rsp_vld_b(rsp_vld_b), .rsp_tag_b(rsp_tag_b), .rsp_data_b(rsp_data_b)
  );

  always #5 clk = ~clk;

  // SRAM model with a read latency of one cycle
  always @(posedge clk) begin
    sram_rd_data_a <= sram_read_vld_a ? {16'hD0A0, sram_read_cmd_a} : 32'h0;
    sram_rd_data_b <= sram_read_vld_b ? {16'hD0B0, sram_read_cmd_b} : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_vld_a = 1'b0; req_cmd_a = '0; req_tag_a = '0;
    req_vld_b = 1'b0; req_cmd_b = '0; req_tag_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (req_rdy_a !== 1'b1) begin failures++; $display("FAIL reset_rdy_a got=%b exp=1", req_rdy_a); end
    checks++; if (req_rdy_b !== 1'b1) begin failures++; $display("FAIL reset_rdy_b got=%b exp=1", req_rdy_b); end
    checks++; if (sram_read_vld_a !== 1'b0) begin failures++; $display("FAIL reset_sram_vld_a got=%b exp=0", sram_read_vld_a); end
    checks++; if (sram_read_vld_b !== 1'b0) begin failures++; $display("FAIL reset_sram_vld_b got=%b exp=0", sram_read_vld_b); end
    checks++; if (rsp_vld_a !== 1'b0 || rsp_vld_b !== 1'b0) begin failures++; $display("FAIL reset_rsp_vld got=%b%b exp=00", rsp_vld_a, rsp_vld_b); end
    checks++; if (rsp_tag_a !== 8'h0 || rsp_tag_b !== 8'h0) begin failures++; $display("FAIL reset_rsp_tag got=%h/%h exp=00/00", rsp_tag_a, rsp_tag_b); end
    checks++; if (rsp_data_a !== 32'h0 || rsp_data_b !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h/%h exp=0/0", rsp_data_a, rsp_data_b); end
  endtask

  task automatic test_no_conflict();
    req_vld_a = 1'b1; req_cmd_a = 16'h8012; req_tag_a = 8'h11;
    req_vld_b = 1'b1; req_cmd_b = 16'h0034; req_tag_b = 8'h22;
    tick();
    idle_inputs();
    checks++; if (sram_read_vld_a !== 1'b1 || sram_read_vld_b !== 1'b1) begin failures++; $display("FAIL nc_issue_vld got=%b%b exp=11", sram_read_vld_a, sram_read_vld_b); end
    checks++; if (sram_read_cmd_a !== 16'h8012) begin failures++; $display("FAIL nc_cmd_a got=%h exp=8012", sram_read_cmd_a); end
    checks++; if (sram_read_cmd_b !== 16'h0034) begin failures++; $display("FAIL nc_cmd_b got=%h exp=0034", sram_read_cmd_b); end
    checks++; if (rsp_vld_a !== 1'b0) begin failures++; $display("FAIL nc_early_rsp got=%b exp=0", rsp_vld_a); end
    tick();
    checks++; if (rsp_vld_a !== 1'b1 || rsp_vld_b !== 1'b1) begin failures++; $display("FAIL nc_rsp_vld got=%b%b exp=11", rsp_vld_a, rsp_vld_b); end
    checks++; if (rsp_tag_a !== 8'h11) begin failures++; $display("FAIL nc_tag_a got=%h exp=11", rsp_tag_a); end
    checks++; if (rsp_tag_b !== 8'h22) begin failures++; $display("FAIL nc_tag_b got=%h exp=22", rsp_tag_b); end
    checks++; if (rsp_data_a !== 32'hD0A0_8012) begin failures++; $display("FAIL nc_data_a got=%h exp=d0a08012", rsp_data_a); end
    checks++; if (rsp_data_b !== 32'hD0B0_0034) begin failures++; $display("FAIL nc_data_b got=%h exp=d0b00034", rsp_data_b); end
    checks++; if (sram_read_vld_a !== 1'b0 || sram_read_vld_b !== 1'b0) begin failures++; $display("FAIL nc_idle_vld got=%b%b exp=00", sram_read_vld_a, sram_read_vld_b); end
    checks++; if (sram_read_cmd_a !== 16'h8000 || sram_read_cmd_b !== 16'h0000) begin failures++; $display("FAIL nc_idle_cmd got=%h/%h exp=8000/0000", sram_read_cmd_a, sram_read_cmd_b); end
    tick();
    checks++; if (rsp_vld_a !== 1'b0 || rsp_vld_b !== 1'b0) begin failures++; $display("FAIL nc_rsp_clear got=%b%b exp=00", rsp_vld_a, rsp_vld_b); end
  endtask

  task automatic test_conflict();
    // rr starts at 0, so A wins the first conflict
    req_vld_a = 1'b1; req_cmd_a = 16'h0001; req_tag_a = 8'h33;
    req_vld_b = 1'b1; req_cmd_b = 16'h0002; req_tag_b = 8'h44;
    tick();
    idle_inputs();
    checks++; if (sram_read_vld_a !== 1'b1 || sram_read_vld_b !== 1'b0) begin failures++; $display("FAIL cf1_t1_vld got=%b%b exp=10", sram_read_vld_a, sram_read_vld_b); end
    checks++; if (sram_read_cmd_a !== 16'h0001) begin failures++; $display("FAIL cf1_t1_cmd_a got=%h exp=0001", sram_read_cmd_a); end
    tick();
    checks++; if (sram_read_vld_a !== 1'b0 || sram_read_vld_b !== 1'b1) begin failures++; $display("FAIL cf1_t2_vld got=%b%b exp=01", sram_read_vld_a, sram_read_vld_b); end
    checks++; if (sram_read_cmd_b !== 16'h0002) begin failures++; $display("FAIL cf1_t2_cmd_b got=%h exp=0002", sram_read_cmd_b); end
    checks++; if (sram_read_cmd_a !== 16'h8000) begin failures++; $display("FAIL cf1_idle_cmd_a got=%h exp=8000", sram_read_cmd_a); end
    checks++; if (rsp_vld_a !== 1'b1 || rsp_tag_a !== 8'h33) begin failures++; $display("FAIL cf1_rsp_a got=%b/%h exp=1/33", rsp_vld_a, rsp_tag_a); end
    tick();
    checks++; if (rsp_vld_b !== 1'b1 || rsp_tag_b !== 8'h44 || rsp_vld_a !== 1'b0) begin failures++; $display("FAIL cf1_rsp_b got=%b/%h a=%b exp=1/44 a=0", rsp_vld_b, rsp_tag_b, rsp_vld_a); end
    // rr is now 1, so B wins the next conflict (channel 1)
    req_vld_a = 1'b1; req_cmd_a = 16'h8005; req_tag_a = 8'h55;
    req_vld_b = 1'b1; req_cmd_b = 16'h8006; req_tag_b = 8'h66;
    tick();
    idle_inputs();
    checks++; if (sram_read_vld_a !== 1'b0 || sram_read_vld_b !== 1'b1) begin failures++; $display("FAIL cf2_t1_vld got=%b%b exp=01", sram_read_vld_a, sram_read_vld_b); end
    checks++; if (sram_read_cmd_a !== 16'h0000 || sram_read_cmd_b !== 16'h8006) begin failures++; $display("FAIL cf2_t1_cmd got=%h/%h exp=0000/8006", sram_read_cmd_a, sram_read_cmd_b); end
    tick();
    checks++; if (sram_read_vld_a !== 1'b1 || sram_read_vld_b !== 1'b0 || sram_read_cmd_a !== 16'h8005) begin failures++; $display("FAIL cf2_t2 got=%b%b/%h exp=10/8005", sram_read_vld_a, sram_read_vld_b, sram_read_cmd_a); end
    checks++; if (rsp_vld_b !== 1'b1 || rsp_tag_b !== 8'h66) begin failures++; $display("FAIL cf2_rsp_b got=%b/%h exp=1/66", rsp_vld_b, rsp_tag_b); end
    tick();
    checks++; if (rsp_vld_a !== 1'b1 || rsp_tag_a !== 8'h55) begin failures++; $display("FAIL cf2_rsp_a got=%b/%h exp=1/55", rsp_vld_a, rsp_tag_a); end
    tick();
  endtask

  // Both ports push 8 requests on channel 0. The grants must alternate A,B,... with no gap.
  task automatic test_back_to_back();
    int sent_a = 0;
    int sent_b = 0;
    int first = -1;
    int last = -1;
    int both = 0;
    qa.delete(); qb.delete(); gseq.delete();
    fork
      begin : push_a_p
        int tries = 0;
        logic acc;
        while (sent_a < 8 && tries < 100) begin
          req_vld_a = 1'b1; req_cmd_a = 16'(sent_a); req_tag_a = 8'hA0 + 8'(sent_a);
          acc = req_rdy_a;
          tick();
          tries++;
          if (acc) sent_a++;
        end
        req_vld_a = 1'b0;
      end
      begin : push_b_p
        int tries = 0;
        logic acc;
        while (sent_b < 8 && tries < 100) begin
          req_vld_b = 1'b1; req_cmd_b = 16'h0100 + 16'(sent_b); req_tag_b = 8'hB0 + 8'(sent_b);
          acc = req_rdy_b;
          tick();
          tries++;
          if (acc) sent_b++;
        end
        req_vld_b = 1'b0;
      end
      begin : mon_p
        for (int cyc = 0; cyc < 40; cyc++) begin
          tick();
          if (sram_read_vld_a && sram_read_vld_b) both++;
          if (sram_read_vld_a) begin gseq.push_back(0); if (first < 0) first = cyc; last = cyc; end
          if (sram_read_vld_b) begin gseq.push_back(1); if (first < 0) first = cyc; last = cyc; end
          if (rsp_vld_a) qa.push_back(rsp_tag_a);
          if (rsp_vld_b) qb.push_back(rsp_tag_b);
        end
      end
    join
    checks++; if (sent_a != 8 || sent_b != 8) begin failures++; $display("FAIL b2b_sent got=%0d/%0d exp=8/8", sent_a, sent_b); end
    checks++; if (both != 0) begin failures++; $display("FAIL b2b_collision got=%0d exp=0", both); end
    checks++; if (gseq.size() != 16) begin failures++; $display("FAIL b2b_grants got=%0d exp=16", gseq.size()); end
    for (int i = 0; i < gseq.size(); i++) begin
      checks++; if (gseq[i] != (i % 2)) begin failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, gseq[i], i % 2); end
    end
    checks++; if (last - first != 15) begin failures++; $display("FAIL b2b_gapless span got=%0d exp=15", last - first); end
    checks++; if (qa.size() != 8 || qb.size() != 8) begin failures++; $display("FAIL b2b_rsp_count got=%0d/%0d exp=8/8", qa.size(), qb.size()); end
    for (int i = 0; i < qa.size(); i++) begin
      checks++; if (qa[i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL b2b_tag_a[%0d] got=%h exp=%h", i, qa[i], 8'hA0 + 8'(i)); end
    end
    for (int i = 0; i < qb.size(); i++) begin
      checks++; if (qb[i] !== 8'hB0 + 8'(i)) begin failures++; $display("FAIL b2b_tag_b[%0d] got=%h exp=%h", i, qb[i], 8'hB0 + 8'(i)); end
    end
  endtask

  // A pushes every cycle while B keeps conflicting heads. rr is 1 here, so B wins first,
  // FIFO A fills, and ready drops in the second cycle.
  task automatic test_backpressure();
    int sent_a = 0;
    int sent_b = 0;
    qa.delete(); qb.delete(); rdyseq.delete();
    fork
      begin : bp_a_p
        int tries = 0;
        logic acc;
        while (sent_a < 6 && tries < 100) begin
          req_vld_a = 1'b1; req_cmd_a = 16'h0200 + 16'(sent_a); req_tag_a = 8'hC0 + 8'(sent_a);
          acc = req_rdy_a;
          tick();
          tries++;
          if (acc) sent_a++;
        end
        req_vld_a = 1'b0;
      end
      begin : bp_b_p
        int tries = 0;
        logic acc;
        while (sent_b < 4 && tries < 100) begin
          req_vld_b = 1'b1; req_cmd_b = 16'h0300 + 16'(sent_b); req_tag_b = 8'hD0 + 8'(sent_b);
          acc = req_rdy_b;
          tick();
          tries++;
          if (acc) sent_b++;
        end
        req_vld_b = 1'b0;
      end
      begin : bp_mon_p
        for (int cyc = 0; cyc < 40; cyc++) begin
          tick();
          rdyseq.push_back(req_rdy_a);
          if (rsp_vld_a) qa.push_back(rsp_tag_a);
          if (rsp_vld_b) qb.push_back(rsp_tag_b);
        end
      end
    join
    checks++; if (rdyseq[0] !== 1'b1) begin failures++; $display("FAIL bp_rdy_c1 got=%b exp=1", rdyseq[0]); end
    checks++; if (rdyseq[1] !== 1'b0) begin failures++; $display("FAIL bp_rdy_full got=%b exp=0", rdyseq[1]); end
    checks++; if (qa.size() != 6 || qb.size() != 4) begin failures++; $display("FAIL bp_rsp_count got=%0d/%0d exp=6/4", qa.size(), qb.size()); end
    for (int i = 0; i < qa.size(); i++) begin
      checks++; if (qa[i] !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL bp_tag_a[%0d] got=%h exp=%h", i, qa[i], 8'hC0 + 8'(i)); end
    end
    for (int i = 0; i < qb.size(); i++) begin
      checks++; if (qb[i] !== 8'hD0 + 8'(i)) begin failures++; $display("FAIL bp_tag_b[%0d] got=%h exp=%h", i, qb[i], 8'hD0 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_op();
    req_vld_a = 1'b1; req_cmd_a = 16'h0010; req_tag_a = 8'hE0;
    req_vld_b = 1'b1; req_cmd_b = 16'h0020; req_tag_b = 8'hF0;
    tick();
    // First conflict grant. The next pair is queued behind it.
    checks++; if ((sram_read_vld_a ^ sram_read_vld_b) !== 1'b1) begin failures++; $display("FAIL rm_one_grant got=%b%b exp=one", sram_read_vld_a, sram_read_vld_b); end
    req_cmd_a = 16'h0011; req_tag_a = 8'hE1;
    req_cmd_b = 16'h0021; req_tag_b = 8'hF1;
    tick();
    idle_inputs();
    checks++; if ((rsp_vld_a | rsp_vld_b) !== 1'b1) begin failures++; $display("FAIL rm_pre_rsp got=%b%b exp=one", rsp_vld_a, rsp_vld_b); end
    // Reset while a read is issued this cycle and three entries remain queued
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_vld_a !== 1'b0 || rsp_vld_b !== 1'b0 || sram_read_vld_a !== 1'b0 || sram_read_vld_b !== 1'b0) begin
        failures++; $display("FAIL rm_post[%0d] rsp=%b%b sram=%b%b exp=00/00", i, rsp_vld_a, rsp_vld_b, sram_read_vld_a, sram_read_vld_b);
      end
      checks++; if (req_rdy_a !== 1'b1 || req_rdy_b !== 1'b1) begin failures++; $display("FAIL rm_rdy[%0d] got=%b%b exp=11", i, req_rdy_a, req_rdy_b); end
      tick();
    end
    // rr is back to 0, so A wins
    req_vld_a = 1'b1; req_cmd_a = 16'h8077; req_tag_a = 8'h77;
    req_vld_b = 1'b1; req_cmd_b = 16'h8088; req_tag_b = 8'h88;
    tick();
    idle_inputs();
    checks++; if (sram_read_vld_a !== 1'b1 || sram_read_vld_b !== 1'b0 || sram_read_cmd_a !== 16'h8077) begin failures++; $display("FAIL rm_rr0 got=%b%b/%h exp=10/8077", sram_read_vld_a, sram_read_vld_b, sram_read_cmd_a); end
    tick();
    checks++; if (rsp_vld_a !== 1'b1 || rsp_tag_a !== 8'h77 || sram_read_vld_b !== 1'b1) begin failures++; $display("FAIL rm_next got=%b/%h b=%b exp=1/77 b=1", rsp_vld_a, rsp_tag_a, sram_read_vld_b); end
    tick();
    checks++; if (rsp_vld_b !== 1'b1 || rsp_tag_b !== 8'h88) begin failures++; $display("FAIL rm_rsp_b got=%b/%h exp=1/88", rsp_vld_b, rsp_tag_b); end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_no_conflict();
    test_conflict();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_cache_sram_pair_rd_sched.md
Name: vec_cache_sram_pair_rd_sched

Overview:
- Read-request scheduler placed directly upstream of the two-instance SRAM group.
- Accepts read requests on two independent ports (A, B), each with valid/ready handshake.
- When both head requests target the same channel_id, serialises them and guarantees the SRAM group never sees a same-channel collision.
- Tags each issued read and returns data with its tag after a fixed read latency.

Parameters:
- TAG_W, 8: width of the request/response tag.
- FIFO_DEPTH, 2: entries per input FIFO (power of 2, ≥2).
- RD_LAT, 1: cycles from sram_read_vld_x to valid sram_rd_data_x.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_vld_a  in  1  port A request valid.
- req_rdy_a  out  1  port A ready; equals "FIFO A not full".
- req_cmd_a  in  sram_inst_cmd_t  port A read command.
- req_tag_a  in  TAG_W  port A tag.
- req_vld_b / req_rdy_b / req_cmd_b / req_tag_b: as port A, for port B.
- sram_read_vld_a  out  1  to SRAM group read_vld_a.
- sram_read_cmd_a  out  sram_inst_cmd_t  to SRAM group read_cmd_a.
- sram_read_vld_b / sram_read_cmd_b  out: as above, for slot b.
- sram_rd_data_a  in  32  from SRAM group rd_data_a.
- sram_rd_data_b  in  32  from SRAM group rd_data_b.
- rsp_vld_a  out  1  response valid, slot a.
- rsp_tag_a  out  TAG_W  response tag, slot a.
- rsp_data_a  out  32  response data, slot a.
- rsp_vld_b / rsp_tag_b / rsp_data_b  out: as above, for slot b.

Behaviour:
- Clocking and reset: single clock, synchronous active-high rst.
  - Reset clears both FIFOs, the response pipelines and rr_ptr (0 = A preferred).
  - After reset: req_rdy_* = 1; sram_read_vld_* = 0; rsp_vld_* = 0; rsp_tag_*/rsp_data_* = 0.
  - Reset mid-operation drops all queued and in-flight requests; no responses for them are ever produced.
- Input: push when req_vld_x && req_rdy_x. Push and pop in the same cycle on a full FIFO is not allowed; ready depends only on registered occupancy.
- Issue (combinational from FIFO heads hA, hB):
  - Both heads valid, different channel_id: issue both (hA on slot a, hB on slot b); pop both.
  - Both heads valid, same channel_id: issue only the rr_ptr winner; the loser stays in its FIFO; rr_ptr toggles to the loser.
  - One head valid: issue it; rr_ptr unchanged.
  - Winner placement: A's request always occupies slot a and B's always slot b.
  - Idle-slot rule: when slot a is idle, sram_read_cmd_a.dest_ram_id.channel_id = ~channel_id of the slot-b request. The SRAM group routes on slot a's channel_id, so an idle slot must not steer slot b onto the wrong SRAM. All other fields of an idle slot's cmd are 0.
  - When slot b is idle, its cmd is 0.
- Latency: request accepted at cycle T issues at T+1 at the earliest; its response appears at T+1+RD_LAT.
- Response pipeline: per slot, an RD_LAT-deep shift of {vld, tag}. rsp_data_x = sram_rd_data_x, qualified by rsp_vld_x. Responses have no backpressure.
- Ordering: per-port order is preserved. No cross-port ordering is guaranteed.
- Starvation: a request conflicting on every cycle is issued within 2 cycles of reaching its FIFO head.

Test Plan:
- Reset then idle: rst high for 2 cycles → req_rdy_a=req_rdy_b=1, sram_read_vld_*=0, rsp_vld_*=0.
- No conflict: A (channel 1, tag 0x11) and B (channel 0, tag 0x22) accepted at cycle T → both issued at T+1; with RD_LAT=1 at T+2, rsp_vld_a=rsp_vld_b=1, rsp_tag_a=0x11, rsp_tag_b=0x22.
- Conflict: A and B both channel 0 at T, rr_ptr=0 → T+1: only slot a valid; T+2: B issued on slot b with slot a channel_id=1; rr_ptr=1 afterwards.
- Continuous conflict streams, 8 requests per port → grants alternate A,B,A,B; all 16 tags returned in per-port order; no idle cycle once both FIFOs are non-empty.
- Backpressure: hold B heads conflicting while pushing A every cycle → req_rdy_a deasserts when FIFO A holds FIFO_DEPTH entries; no push is lost or duplicated.
- Reset with 2 entries queued and 1 read in flight → no rsp_vld_* after reset; next request issues normally with rr_ptr=0.
